axis_sort_scheduler: RTL and testbench
======================================

# axis_sort_scheduler

Frame-level round-robin scheduler that shares one `axis_l_sorter` instance among `N_SRC` AXI-Stream sources, e.g. electrode channel groups. It grants the sorter input to one source for a whole frame (through `tlast`) and limits the number of frames in flight inside the sorter. It tags every sorter output beat with the originating source id on `m_axis_tdest`, so downstream logic can route sorted results back. It sits between the per-group acquisition streams and the sorter, and between the sorter output and the DMA/packer.

## Interface
- `C_AXIS_TDATA_WIDTH`, 32, data width of every stream.
- `N_SRC`, 4, number of requesting sources (2..16). `ID_W` = max(1, $clog2(`N_SRC`)) is derived.
- `MAX_INFLIGHT`, 2, maximum frames granted but not yet fully emitted by the sorter (1..8). Sets the depth of the id FIFO.
- `MAX_BEATS`, 1024, frame-length limit; used only with `L_SORT_SCHED_TRUNC_EN`.

Ports:
- `aclk` in 1: single clock for all interfaces.
- `aresetn` in 1: synchronous, active-low reset.
- `s_axis_tdata` in N_SRC*C_AXIS_TDATA_WIDTH: source data. Source i occupies slice [i*W +: W].
- `s_axis_tvalid` in N_SRC: per-source valid.
- `s_axis_tlast` in N_SRC: per-source end of frame.
- `s_axis_tready` out N_SRC: per-source ready, one-hot or zero.
- `srt_s_axis_tdata` out C_AXIS_TDATA_WIDTH: data to the sorter input.
- `srt_s_axis_tvalid` out 1: valid to the sorter input.
- `srt_s_axis_tlast` out 1: last to the sorter input.
- `srt_s_axis_tready` in 1: ready from the sorter input.
- `srt_m_axis_tdata` in C_AXIS_TDATA_WIDTH: sorter output data.
- `srt_m_axis_tvalid` in 1: sorter output valid.
- `srt_m_axis_tlast` in 1: sorter output last.
- `srt_m_axis_tready` out 1: ready to the sorter output.
- `m_axis_tdata` out C_AXIS_TDATA_WIDTH: tagged output data.
- `m_axis_tvalid` out 1: tagged output valid.
- `m_axis_tlast` out 1: tagged output last.
- `m_axis_tdest` out ID_W: source id of the current output frame.
- `m_axis_tready` in 1: downstream ready.
- `inflight` out $clog2(MAX_INFLIGHT+1): number of frames currently in flight.
- `err_orphan` out 1: sticky. Set when the sorter emits a beat while no frame is in flight.
- `err_trunc` out 1: sticky. Set when a frame is truncated; constant 0 without the macro.

## Operation
- FSM states: ARB, XFER, plus DRAIN when the macro is defined. Reset state is ARB.
- ARB:
  - Grant only if at least one `s_axis_tvalid` is high and `inflight` < `MAX_INFLIGHT`.
  - Winner is the first valid source, scanning from `last_grant`+1 modulo `N_SRC`.
  - On grant: register `grant_id`, update `last_grant`, push `grant_id` into the id FIFO, and go to XFER.
  - Otherwise stay in ARB.
- XFER, combinational pass-through of the granted source only:
  - `srt_s_axis_tdata`, `srt_s_axis_tvalid` and `srt_s_axis_tlast` come from source `grant_id`.
  - `s_axis_tready[grant_id]` = `srt_s_axis_tready`; all other readies are 0.
  - The state advances on the tlast handshake (`srt_s_axis_tvalid` & `srt_s_axis_tready` & `srt_s_axis_tlast`) and returns to ARB.
- In ARB, all `s_axis_tready` bits are 0 and `srt_s_axis_tvalid` is 0.
- Output side, when the id FIFO is non-empty:
  - `m_axis_*` mirrors `srt_m_axis_*`.
  - `srt_m_axis_tready` = `m_axis_tready`.
  - `m_axis_tdest` = FIFO head.
  - A handshake with `m_axis_tlast` high pops the FIFO.
- Output side, when the id FIFO is empty:
  - `m_axis_tvalid` is 0 and `srt_m_axis_tready` is 1, so orphan beats are dropped.
  - Any `srt_m_axis_tvalid` beat sets `err_orphan`.
- `inflight` equals the FIFO occupancy. A push and a pop in the same cycle leave it unchanged.
- A FIFO push never occurs while full, because the grant requires `inflight` < `MAX_INFLIGHT`.
- `last_grant` resets to `N_SRC`-1, so source 0 has first priority after reset.
- `aresetn` low mid-frame:
  - Abandons the frame and clears the FSM, the FIFO, the counters and both error flags.
  - No further beats are accepted from the source until it is granted again.

## Timing
- Reset values:
  - `s_axis_tready`, `srt_s_axis_tvalid`, `srt_s_axis_tlast` = 0.
  - `m_axis_tvalid`, `m_axis_tlast` = 0. `m_axis_tdest` = 0.
  - `srt_m_axis_tready` = 1.
  - `inflight` = 0. `err_orphan` and `err_trunc` = 0.
- The grant is registered. A source whose tvalid is high in ARB at edge N has its first beat presented to the sorter in cycle N+1.
- Frame gap: one ARB cycle between the tlast handshake and the next frame's first beat.
- Input and output paths add zero cycles of data latency (combinational muxes).
- A frame's `m_axis_tlast` pop frees a slot. The freed slot is usable for a grant in the next ARB evaluation, i.e. the cycle after the pop.

## Configuration
- Macro: `L_SORT_SCHED_TRUNC_EN`.
- Defined:
  - A beat counter runs in XFER.
  - On beat number `MAX_BEATS` without source tlast, the scheduler forces `srt_s_axis_tlast`=1 on that beat and sets `err_trunc`.
  - If the source has not ended the frame, the FSM enters DRAIN. There `s_axis_tready[grant_id]`=1, beats are discarded and `srt_s_axis_tvalid`=0 until the source tlast handshake, then the FSM returns to ARB.
  - A source tlast on exactly beat `MAX_BEATS` is normal: no error, no DRAIN.
- Undefined: no counter, no DRAIN state, `err_trunc` tied 0, frames of unbounded length.

## Test plan
- Single source: source 0 sends a 4-beat frame 1,2,3,4 with the sorter always ready. Required response:
  - Sorter input sees 4 beats starting one cycle after tvalid.
  - `inflight` goes 0→1→0 after the sorter emits its tlast.
  - Output `m_axis_tdest`=0.
- Round robin: all 4 sources hold 2-beat frames. Required response:
  - Grant order 0,1,2,3,0.
  - `m_axis_tdest` sequence 0,1,2,3 matches sorter output order.
- In-flight limit, `MAX_INFLIGHT`=2, sorter output stalled: after two frames are granted, a third requester's `s_axis_tready` stays 0. It is granted in the cycle after the first output tlast pop.
- Backpressure: toggle `m_axis_tready` every cycle. Required response: `srt_m_axis_tready` mirrors it and no beat is lost or duplicated.
- Orphan and reset:
  - A sorter output beat with `inflight`=0 is dropped and sets `err_orphan`=1.
  - Asserting `aresetn`=0 for 1 cycle mid-frame clears `err_orphan`, `inflight` and the grant.
- With `L_SORT_SCHED_TRUNC_EN` and `MAX_BEATS`=8, a 12-beat frame:
  - Sorter sees 8 beats, tlast on beat 8.
  - Beats 9-12 are drained.
  - `err_trunc`=1.
  - The next grant follows the source tlast.

Source files
------------

// File: rtl/axis_sort_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axis_sort_scheduler
// Brief    : Frame-level round-robin sharing of one sorter among N_SRC streams,
//            tagging sorter output with the source id. L_SORT_SCHED_TRUNC_EN
//            adds MAX_BEATS frame truncation with a drain state.
// Revision : 1.0 - initial release
// ============================================================================
module axis_sort_scheduler #(
    parameter int  C_AXIS_TDATA_WIDTH = 32,
    parameter int  N_SRC              = 4,
    parameter int  MAX_INFLIGHT       = 2,
    parameter int  MAX_BEATS          = 1024,
    localparam int ID_W               = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int INFL_W             = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [N_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]                    s_axis_tvalid,
    input  logic [N_SRC-1:0]                    s_axis_tlast,
    output logic [N_SRC-1:0]                    s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]       srt_s_axis_tdata,
    output logic                                srt_s_axis_tvalid,
    output logic                                srt_s_axis_tlast,
    input  logic                                srt_s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]       srt_m_axis_tdata,
    input  logic                                srt_m_axis_tvalid,
    input  logic                                srt_m_axis_tlast,
    output logic                                srt_m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    output logic [ID_W-1:0]                     m_axis_tdest,
    input  logic                                m_axis_tready,
    output logic [INFL_W-1:0]                   inflight,
    output logic                                err_orphan,
    output logic                                err_trunc
);

    localparam int c_ptr_w = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int c_w     = C_AXIS_TDATA_WIDTH;

`ifdef L_SORT_SCHED_TRUNC_EN
    typedef enum logic [1:0] {ST_ARB = 2'd0, ST_XFER = 2'd1, ST_DRAIN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_ARB = 2'd0, ST_XFER = 2'd1} state_t;
`endif

    state_t              r_state;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_fifo [MAX_INFLIGHT];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [INFL_W-1:0]   r_count;
    logic                r_err_orphan;

    logic                w_req_found;
    logic [ID_W-1:0]     w_req_id;
    logic                w_grant;
    logic                w_fifo_empty;
    logic                w_pop;
    logic [c_w-1:0]      w_src_data;
    logic                w_src_valid;
    logic                w_src_last;
    logic                w_at_limit;
    logic                w_in_hs;

`ifdef L_SORT_SCHED_TRUNC_EN
    localparam int c_beat_w = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    logic [c_beat_w-1:0] r_beat_cnt;
    logic                r_err_trunc;

    assign w_at_limit = (r_beat_cnt == c_beat_w'(MAX_BEATS - 1));
    assign err_trunc  = r_err_trunc;
`else
    assign w_at_limit = 1'b0;
    assign err_trunc  = 1'b0;
`endif

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Rotating priority: first requester after the previous winner
    always_comb begin
        w_req_found = 1'b0;
        w_req_id    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!w_req_found && s_axis_tvalid[(int'(r_last_grant) + k) % N_SRC]) begin
                w_req_found = 1'b1;
                w_req_id    = ID_W'((int'(r_last_grant) + k) % N_SRC);
            end
        end
    end

    assign w_fifo_empty = (r_count == '0);
    assign w_grant      = (r_state == ST_ARB) && w_req_found && (r_count < INFL_W'(MAX_INFLIGHT));
    assign w_src_data   = s_axis_tdata[int'(r_grant_id)*c_w +: c_w];
    assign w_src_valid  = s_axis_tvalid[r_grant_id];
    assign w_src_last   = s_axis_tlast[r_grant_id];
    assign w_in_hs      = (r_state == ST_XFER) && w_src_valid && srt_s_axis_tready;

    always_comb begin
        srt_s_axis_tdata  = w_src_data;
        srt_s_axis_tvalid = 1'b0;
        srt_s_axis_tlast  = 1'b0;
        s_axis_tready     = '0;
        case (r_state)
            ST_XFER: begin
                srt_s_axis_tvalid         = w_src_valid;
                srt_s_axis_tlast          = w_src_last | w_at_limit;
                s_axis_tready[r_grant_id] = srt_s_axis_tready;
            end
`ifdef L_SORT_SCHED_TRUNC_EN
            ST_DRAIN: s_axis_tready[r_grant_id] = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= ST_ARB;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(N_SRC - 1);
`ifdef L_SORT_SCHED_TRUNC_EN
            r_beat_cnt   <= '0;
            r_err_trunc  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_grant) begin
                        r_grant_id   <= w_req_id;
                        r_last_grant <= w_req_id;
                        r_state      <= ST_XFER;
`ifdef L_SORT_SCHED_TRUNC_EN
                        r_beat_cnt   <= '0;
`endif
                    end
                end
                ST_XFER: begin
                    if (w_in_hs) begin
`ifdef L_SORT_SCHED_TRUNC_EN
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_at_limit && !w_src_last) begin
                            r_err_trunc <= 1'b1;
                            r_state     <= ST_DRAIN;
                        end else if (w_at_limit || w_src_last) begin
                            r_state <= ST_ARB;
                        end
`else
                        if (w_src_last) r_state <= ST_ARB;
`endif
                    end
                end
`ifdef L_SORT_SCHED_TRUNC_EN
                ST_DRAIN: begin
                    if (w_src_valid && w_src_last) r_state <= ST_ARB;
                end
`endif
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Id FIFO: one entry per frame granted and not yet fully emitted
    assign w_pop = !w_fifo_empty && srt_m_axis_tvalid && m_axis_tready && srt_m_axis_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_grant) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)   r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_fifo_empty && srt_m_axis_tvalid) r_err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_grant) r_fifo[r_wr_ptr] <= w_req_id;
    end

    // With nothing in flight, sorter output is swallowed rather than stalled
    assign m_axis_tdata      = srt_m_axis_tdata;
    assign m_axis_tvalid     = !w_fifo_empty && srt_m_axis_tvalid;
    assign m_axis_tlast      = !w_fifo_empty && srt_m_axis_tlast;
    assign m_axis_tdest      = w_fifo_empty ? '0 : r_fifo[r_rd_ptr];
    assign srt_m_axis_tready = w_fifo_empty || m_axis_tready;
    assign inflight          = r_count;
    assign err_orphan        = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_axis_sort_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sort_scheduler
// Brief    : Scoreboard bench for axis_sort_scheduler with a behavioural sorter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sort_scheduler;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MI = 2;
`ifdef L_SORT_SCHED_TRUNC_EN
    localparam int MB = 8;
`else
    localparam int MB = 1024;
`endif

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [N*W-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [W-1:0]   srt_s_axis_tdata, srt_m_axis_tdata, m_axis_tdata;
    logic           srt_s_axis_tvalid, srt_s_axis_tlast, srt_s_axis_tready;
    logic           srt_m_axis_tvalid, srt_m_axis_tlast, srt_m_axis_tready;
    logic           m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [1:0]     m_axis_tdest;
    logic [1:0]     inflight;
    logic           err_orphan, err_trunc;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] src_q [N][$];
    logic [32:0] srt_out_q [$];
    logic [31:0] cur_frame [$];
    logic [34:0] exp_q [$];
    bit          out_en = 1'b1;
    bit          bp_mode = 1'b0;

    axis_sort_scheduler #(
        .C_AXIS_TDATA_WIDTH(W), .N_SRC(N), .MAX_INFLIGHT(MI), .MAX_BEATS(MB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .srt_s_axis_tdata(srt_s_axis_tdata), .srt_s_axis_tvalid(srt_s_axis_tvalid),
        .srt_s_axis_tlast(srt_s_axis_tlast), .srt_s_axis_tready(srt_s_axis_tready),
        .srt_m_axis_tdata(srt_m_axis_tdata), .srt_m_axis_tvalid(srt_m_axis_tvalid),
        .srt_m_axis_tlast(srt_m_axis_tlast), .srt_m_axis_tready(srt_m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
        .m_axis_tready(m_axis_tready), .inflight(inflight),
        .err_orphan(err_orphan), .err_trunc(err_trunc)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic src_beat(input int s, input logic [31:0] d, input bit l);
        src_q[s].push_back({l, d});
    endtask

    task automatic exp_beat(input logic [1:0] dest, input logic [31:0] d, input bit l);
        exp_q.push_back({dest, l, d});
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0) || (srt_out_q.size() != 0) || (cur_frame.size() != 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy() && n < 400) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_idle: still busy after %0d cycles, want idle", name, n);
        end
        repeat (3) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        srt_out_q.delete();
        exp_q.delete();
        repeat (2) @(negedge aclk);
        cur_frame.delete();
        aresetn = 1'b1;
    endtask

    // Sources and a behavioural sorter (sorts each frame ascending)
    initial begin : driver
        logic [N-1:0] hs_s;
        logic         hs_out;
        s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        srt_m_axis_tdata = '0; srt_m_axis_tvalid = 1'b0; srt_m_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge aclk);
            hs_s   = s_axis_tvalid & s_axis_tready;
            hs_out = srt_m_axis_tvalid & srt_m_axis_tready;
            if (srt_s_axis_tvalid && srt_s_axis_tready) begin
                cur_frame.push_back(srt_s_axis_tdata);
                if (srt_s_axis_tlast) begin
                    cur_frame.sort();
                    foreach (cur_frame[k])
                        srt_out_q.push_back({(k == cur_frame.size() - 1), cur_frame[k]});
                    cur_frame.delete();
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++)
                if (hs_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (hs_out && srt_out_q.size() > 0) void'(srt_out_q.pop_front());
            for (int i = 0; i < N; i++) begin
                s_axis_tvalid[i] = (src_q[i].size() > 0);
                {s_axis_tlast[i], s_axis_tdata[i*W +: W]} = (src_q[i].size() > 0) ? src_q[i][0] : 33'd0;
            end
            srt_m_axis_tvalid = out_en && (srt_out_q.size() > 0);
            {srt_m_axis_tlast, srt_m_axis_tdata} = (srt_out_q.size() > 0) ? srt_out_q[0] : 33'd0;
            m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
        end
    end

    initial begin : monitor
        logic [34:0] e;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got beat %0h dest %0d, want none", m_axis_tdata, m_axis_tdest);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {m_axis_tdest, m_axis_tlast, m_axis_tdata}, e);
                    end
                end
                if (inflight != 2'd0) chk("srt_m_tready_mirror", srt_m_axis_tready, m_axis_tready);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        srt_s_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_srt_s_tvalid", srt_s_axis_tvalid, 0);
        chk("rst_srt_s_tlast", srt_s_axis_tlast, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_tdest", m_axis_tdest, 0);
        chk("rst_srt_m_tready", srt_m_axis_tready, 1);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_err_trunc", err_trunc, 0);
        aresetn = 1'b1;

        // Single source, 4-beat frame
        @(negedge aclk);
        src_beat(0, 4, 0); src_beat(0, 1, 0); src_beat(0, 3, 0); src_beat(0, 2, 1);
        exp_beat(0, 1, 0); exp_beat(0, 2, 0); exp_beat(0, 3, 0); exp_beat(0, 4, 1);
        @(negedge aclk);
        chk("t1_arb_no_valid", srt_s_axis_tvalid, 0);
        chk("t1_inflight0", inflight, 0);
        @(negedge aclk);
        chk("t1_first_valid", srt_s_axis_tvalid, 1);
        chk("t1_first_data", srt_s_axis_tdata, 4);
        chk("t1_tready", s_axis_tready, 4'b0001);
        chk("t1_inflight1", inflight, 1);
        wait_idle("t1");
        chk("t1_inflight_end", inflight, 0);

        // Round robin 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_beat(i, i*16 + 2, 0); src_beat(i, i*16 + 1, 1);
        end
        src_beat(0, 32'h41, 0); src_beat(0, 32'h40, 1);
        exp_beat(0, 1, 0);  exp_beat(0, 2, 1);
        exp_beat(1, 17, 0); exp_beat(1, 18, 1);
        exp_beat(2, 33, 0); exp_beat(2, 34, 1);
        exp_beat(3, 49, 0); exp_beat(3, 50, 1);
        exp_beat(0, 32'h40, 0); exp_beat(0, 32'h41, 1);
        wait_idle("t2");

        // In-flight limit with stalled sorter output
        do_reset();
        out_en = 1'b0;
        src_beat(0, 6, 0);  src_beat(0, 5, 1);
        src_beat(1, 8, 0);  src_beat(1, 7, 1);
        src_beat(2, 10, 0); src_beat(2, 9, 1);
        exp_beat(0, 5, 0); exp_beat(0, 6, 1);
        exp_beat(1, 7, 0); exp_beat(1, 8, 1);
        exp_beat(2, 9, 0); exp_beat(2, 10, 1);
        repeat (12) @(negedge aclk);
        chk("t3_inflight_full", inflight, 2);
        chk("t3_tready_blocked", s_axis_tready, 0);
        chk("t3_src2_pending", src_q[2].size(), 2);
        out_en = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(m_axis_tvalid && m_axis_tready && m_axis_tlast) && n < 50);
        chk("t3_pop_seen", (n < 50), 1);
        @(negedge aclk);
        chk("t3_after_pop_tready", s_axis_tready, 0);
        chk("t3_after_pop_inflight", inflight, 1);
        @(negedge aclk);
        chk("t3_regrant_tready", s_axis_tready, 4'b0100);
        wait_idle("t3");

        // Output backpressure toggling each cycle
        do_reset();
        bp_mode = 1'b1;
        src_beat(1, 30, 0); src_beat(1, 10, 0); src_beat(1, 20, 1);
        src_beat(3, 7, 0);  src_beat(3, 9, 0);  src_beat(3, 8, 1);
        exp_beat(1, 10, 0); exp_beat(1, 20, 0); exp_beat(1, 30, 1);
        exp_beat(3, 7, 0);  exp_beat(3, 8, 0);  exp_beat(3, 9, 1);
        wait_idle("t4");
        bp_mode = 1'b0;
        repeat (2) @(negedge aclk);

        // Orphan beat, then reset mid-frame
        srt_out_q.push_back({1'b1, 32'hDEAD});
        repeat (3) @(negedge aclk);
        chk("t5_err_orphan", err_orphan, 1);
        chk("t5_orphan_dropped", srt_out_q.size(), 0);
        src_beat(2, 1, 0); src_beat(2, 2, 0); src_beat(2, 3, 0); src_beat(2, 4, 1);
        repeat (3) @(negedge aclk);
        chk("t5_midframe_inflight", inflight, 1);
        chk("t5_midframe_tready", s_axis_tready, 4'b0100);
        aresetn = 1'b0;
        src_q[2].delete();
        @(negedge aclk);
        aresetn = 1'b1;
        cur_frame.delete();
        chk("t5_rst_err_orphan", err_orphan, 0);
        chk("t5_rst_inflight", inflight, 0);
        chk("t5_rst_tready", s_axis_tready, 0);
        chk("t5_rst_srt_valid", srt_s_axis_tvalid, 0);
        repeat (4) @(negedge aclk);
        chk("t5_no_regrant", s_axis_tready, 0);
        src_beat(3, 3, 0); src_beat(3, 1, 1);
        exp_beat(3, 1, 0); exp_beat(3, 3, 1);
        wait_idle("t5");

`ifdef L_SORT_SCHED_TRUNC_EN
        // 12-beat frame truncated to 8, remainder drained
        do_reset();
        for (int k = 0; k < 12; k++) src_beat(1, 12 - k, (k == 11));
        src_beat(2, 101, 0); src_beat(2, 100, 1);
        for (int k = 5; k <= 12; k++) exp_beat(1, k, (k == 12));
        exp_beat(2, 100, 0); exp_beat(2, 101, 1);
        wait_idle("t6");
        chk("t6_err_trunc", err_trunc, 1);
`else
        chk("t6_err_trunc_tied", err_trunc, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
